// File: rtl/dsm_sequencer.sv
// dsm_sequencer: sample buffering, dither generation, reset sequencing and overload monitoring for the delta-sigma modulator
module dsm_sequencer #(
  parameter int          W            = 16,
  parameter int          OSR          = 64,
  parameter int          FLUSH_CYCLES = 8,
  parameter int          OVL_RUN      = 32,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          DITH_SHIFT   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  input  logic         dith_en,
  input  logic [1:0]   pwm,
  input  logic         stat_clear,
  output logic         dsm_reset,
  output logic [W-1:0] dsm_vin,
  output logic [W-1:0] dsm_dith,
  output logic         sample_tick,
  output logic         overload,
  output logic         underrun,
  output logic [1:0]   state
);
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] FLUSH   = 2'b01;
  localparam logic [1:0] RUN     = 2'b10;
  localparam logic [1:0] RECOVER = 2'b11;
  localparam int OW = $clog2(OSR);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int RW = $clog2(OVL_RUN + 1);

  logic [W-1:0]  mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic [OW-1:0] osr_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] run_cnt, run_next;
  logic [1:0]    pwm_q, nxt;
  logic [15:0]   lfsr, lfsr_adv;
  logic signed [15:0]  lsh;
  logic signed [W-1:0] dith_word;
  logic push, pop, tick, empty, osr_end, flush_done, ovl_set, und_set;

  assign empty      = count == 2'd0;
  assign s_ready    = enable && count != 2'd2;
  assign push       = s_valid && s_ready;
  assign osr_end    = osr_cnt == OW'(OSR - 1);
  assign flush_done = flush_cnt == '0;
  assign run_next   = pwm == 2'b00 ? '0 : pwm == pwm_q ? run_cnt + 1'b1 : RW'(1);
  // enable=0 wins over every other transition; FLUSH and RECOVER share the flush countdown
  assign nxt        = !enable ? IDLE :
                      state == IDLE ? FLUSH :
                      state == RUN ? (run_next == RW'(OVL_RUN) ? RECOVER : RUN) :
                      flush_done ? RUN : state;
  assign tick       = state == RUN && nxt == RUN && osr_end;
  assign pop        = tick && !empty;
  assign ovl_set    = state == RUN && nxt == RECOVER;
  assign und_set    = tick && empty;
  assign lfsr_adv   = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
  assign lsh        = $signed(lfsr) >>> DITH_SHIFT;
  assign dith_word  = W'(lsh);

  // sequencing state, period/flush/run counters and dither LFSR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
      osr_cnt   <= '0;
      run_cnt   <= '0;
      pwm_q     <= 2'b00;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= nxt;
      flush_cnt <= (state == IDLE || state == RUN) ? FW'(FLUSH_CYCLES - 1) : flush_done ? flush_cnt : flush_cnt - 1'b1;
      osr_cnt   <= (state == RUN && nxt == RUN) ? (osr_end ? '0 : osr_cnt + 1'b1) : '0;
      run_cnt   <= (state == RUN && nxt == RUN) ? run_next : '0;
      pwm_q     <= pwm;
      lfsr      <= state == RUN ? lfsr_adv : lfsr;
    end
  end

  // registered modulator-side outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dsm_reset   <= 1'b1;
      dsm_vin     <= '0;
      dsm_dith    <= '0;
      sample_tick <= 1'b0;
    end else begin
      dsm_reset   <= nxt != RUN;
      dsm_vin     <= (nxt == IDLE || nxt == RECOVER) ? '0 : pop ? mem[rd_ptr] : dsm_vin;
      dsm_dith    <= (nxt != IDLE && dith_en) ? dith_word : '0;
      sample_tick <= tick;
    end
  end

  // sticky status; a set event beats a simultaneous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overload <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overload <= ovl_set || (overload && !stat_clear);
      underrun <= und_set || (underrun && !stat_clear);
    end
  end

  // FIFO pointers and occupancy; emptied whenever the sequencer drops to IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (nxt == IDLE) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= s_data;
  end
endmodule

// File: tb/tb_dsm_sequencer.sv
// tb_dsm_sequencer: scoreboard bench for the modulator front-end sequencer
module tb_dsm_sequencer;
  logic        clock = 1'b0;
  logic        reset, enable, s_valid, s_ready, dith_en, stat_clear;
  logic        dsm_reset, sample_tick, overload, underrun;
  logic [15:0] s_data, dsm_vin, dsm_dith;
  logic [1:0]  pwm, state;
  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q [$];

  dsm_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dith_en(dith_en), .pwm(pwm), .stat_clear(stat_clear),
    .dsm_reset(dsm_reset), .dsm_vin(dsm_vin), .dsm_dith(dsm_dith), .sample_tick(sample_tick),
    .overload(overload), .underrun(underrun), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!sample_tick && n < budget);
    chk("tick_arrived", {31'd0, sample_tick}, 32'd1);
  endtask

  always @(negedge clock) begin
    if (reset && sample_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tick_unexpected: got vin %0h und %0b expected no tick", dsm_vin, underrun);
      end else begin
        automatic logic [16:0] e = exp_q.pop_front();
        if ({underrun, dsm_vin} !== e) begin
          failures++;
          $display("FAIL tick_sample: got und %0b vin %0h expected und %0b vin %0h", underrun, dsm_vin, e[16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    dith_en = 1'b0; pwm = 2'b00; stat_clear = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_dsm_reset", dsm_reset, 1);
    chk("rst_vin", dsm_vin, 0);
    chk("rst_dith", dsm_dith, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_ovl", overload, 0);
    chk("rst_und", underrun, 0);
    chk("rst_s_ready", s_ready, 0);
    step(2);
    reset = 1'b1;
    step(1);
    enable = 1'b1; dith_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("flush_state", state, 1);
      chk("flush_dsm_reset", dsm_reset, 1);
      if (i == 0) begin s_valid = 1'b1; s_data = 16'h1000; exp_q.push_back({1'b0, 16'h1000}); end
      if (i == 1) begin s_data = 16'hF000; exp_q.push_back({1'b0, 16'hF000}); end
      if (i == 2) begin s_data = 16'h1234; chk("full_s_ready", s_ready, 0); end
      if (i == 3) s_valid = 1'b0;
    end
    step(1);
    chk("run_state", state, 2);
    chk("run_dsm_reset", dsm_reset, 0);
    chk("first_dith", dsm_dith, 16'hFFAC);
    step(63);
    chk("no_tick_72", sample_tick, 0);
    step(1);
    chk("tick_73", sample_tick, 1);
    exp_q.push_back({1'b1, 16'hF000});
    wait_tick(100);
    wait_tick(100);
    chk("underrun_set", underrun, 1);
    stat_clear = 1'b1; dith_en = 1'b0;
    step(1);
    stat_clear = 1'b0;
    chk("underrun_clr", underrun, 0);
    step(1);
    chk("dith_off", dsm_dith, 0);
    exp_q.push_back({1'b1, 16'hF000});
    wait_tick(100);
    for (int i = 0; i < 20; i++) begin
      pwm = i[0] ? 2'b11 : 2'b01;
      step(1);
    end
    chk("alt_no_ovl", overload, 0);
    chk("alt_state", state, 2);
    pwm = 2'b01;
    step(31);
    chk("run31_state", state, 2);
    chk("run31_ovl", overload, 0);
    step(1);
    pwm = 2'b00;
    chk("ovl_state", state, 3);
    chk("ovl_flag", overload, 1);
    chk("ovl_dsm_reset", dsm_reset, 1);
    chk("ovl_vin", dsm_vin, 0);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("rec_state", state, 3);
      chk("rec_dsm_reset", dsm_reset, 1);
      chk("rec_vin", dsm_vin, 0);
    end
    step(1);
    chk("rec_done_state", state, 2);
    chk("rec_done_dsm_reset", dsm_reset, 0);
    stat_clear = 1'b1;
    step(1);
    stat_clear = 1'b0;
    chk("ovl_clr", overload, 0);
    chk("und_clr2", underrun, 0);
    s_valid = 1'b1; s_data = 16'h0ABC;
    step(1);
    s_valid = 1'b0; pwm = 2'b11;
    step(31);
    chk("neg_run_state", state, 2);
    step(1);
    pwm = 2'b00;
    chk("neg_ovl_state", state, 3);
    chk("neg_ovl_flag", overload, 1);
    step(2);
    enable = 1'b0;
    step(1);
    chk("dis_state", state, 0);
    chk("dis_dsm_reset", dsm_reset, 1);
    chk("dis_vin", dsm_vin, 0);
    chk("dis_s_ready", s_ready, 0);
    chk("dis_ovl_sticky", overload, 1);
    stat_clear = 1'b1;
    step(1);
    stat_clear = 1'b0;
    enable = 1'b1;
    exp_q.push_back({1'b1, 16'h0000});
    wait_tick(100);
    dith_en = 1'b1;
    s_valid = 1'b1; s_data = 16'h5555;
    step(1);
    s_valid = 1'b0;
    step(5);
    chk("pre_rst_dith", dsm_dith == 16'h0, 0);
    reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_dsm_reset", dsm_reset, 1);
    chk("arst_vin", dsm_vin, 0);
    chk("arst_dith", dsm_dith, 0);
    chk("arst_und", underrun, 0);
    chk("arst_tick", sample_tick, 0);
    @(negedge clock);
    reset = 1'b1;
    step(1);
    chk("rerun_flush", state, 1);
    exp_q.push_back({1'b1, 16'h0000});
    wait_tick(100);
    step(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsm_sequencer.md
Name: dsm_sequencer

Overview:
- Front-end controller for the delta-sigma modulator top level.
- Accepts input samples from upstream over a valid/ready handshake into a 2-entry buffer, then presents them to the modulator `vin` input once per oversampling period.
- Generates the dither word for `dith_i` and owns the modulator's synchronous reset for start-up flush and overload recovery.
- Monitors the modulator's 2-bit pwm code for limit-cycle/overload runs and reports sticky status.

Parameters:
- W, 16, sample/vin/dither width (matches modulator T_BITS)
- OSR, 64, clock cycles per input sample (>=2)
- FLUSH_CYCLES, 8, cycles the modulator reset is held on start and recovery (>=1)
- OVL_RUN, 32, consecutive identical nonzero pwm codes that declare overload (>=2)
- LFSR_SEED, 16'hACE1, dither LFSR reset value (nonzero)
- DITH_SHIFT, 8, arithmetic right shift applied to the LFSR word

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; asserted when 0
- enable  in  1  run request
- s_valid  in  1  upstream sample valid
- s_data  in  W  upstream sample, two's complement
- s_ready  out  1  buffer can accept
- dith_en  in  1  dither enable
- pwm  in  2  modulator output code (00 = 0, 01 = +1, 11 = -1)
- stat_clear  in  1  clears sticky status
- dsm_reset  out  1  active-high synchronous reset to the modulator
- dsm_vin  out  W  to modulator vin
- dsm_dith  out  W  to modulator dith_i
- sample_tick  out  1  one-cycle pulse when dsm_vin is updated
- overload  out  1  sticky overload flag
- underrun  out  1  sticky underrun flag
- state  out  2  00 IDLE, 01 FLUSH, 10 RUN, 11 RECOVER

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, dsm_reset=1, dsm_vin=0, dsm_dith=0.
  - sample_tick=0, overload=0, underrun=0.
  - Buffer empty; OSR, flush and run counters = 0; LFSR=LFSR_SEED.
- Outputs: all are registered except s_ready, which is defined as (enable && buffer not full).
- Buffer:
  - 2-entry FIFO. Push occurs when s_valid && s_ready.
  - Push and pop in the same cycle are both honoured; occupancy is then unchanged.
  - Push is blocked when full.
  - In IDLE the buffer is flushed to empty.
- IDLE:
  - dsm_reset=1; dsm_vin and dsm_dith are driven to 0.
  - enable=1 moves to FLUSH on the next edge; flush counter is loaded.
- FLUSH:
  - dsm_reset=1 for exactly FLUSH_CYCLES cycles, then RUN.
  - On entry to RUN, the OSR counter = 0.
- RUN:
  - dsm_reset=0. OSR counter counts 0..OSR-1 and wraps.
  - When the count is OSR-1, on the next edge:
    - sample_tick=1 for one cycle.
    - If the buffer is non-empty: dsm_vin loads the head entry and it is popped.
    - If the buffer is empty: dsm_vin holds its value and underrun sets.
- RECOVER:
  - Entered from RUN when overload is detected. overload sets on the same edge.
  - dsm_reset=1 and dsm_vin=0 for FLUSH_CYCLES cycles.
  - Buffer contents are kept. Then return to RUN with the OSR counter = 0.
- Enable priority: enable=0 in any non-IDLE state goes to IDLE on the next edge, overriding all other transitions.
- Overload detect:
  - Active in RUN only. The run counter increments when pwm equals the previous cycle's pwm and is nonzero.
  - The run counter is reset to 1 on a change to a nonzero code, and to 0 on 00.
  - Reaching OVL_RUN triggers RECOVER.
  - The run counter clears in all other states.
- Dither:
  - 16-bit Galois LFSR, taps mask 16'hB400 (shift right; XOR mask when the LSB is 1).
  - Advances every cycle in RUN only.
  - dsm_dith = dith_en ? sign-extend(lfsr >>> DITH_SHIFT) to W : 0, registered.
- Status:
  - stat_clear=1 clears overload and underrun.
  - If a set event occurs in the same cycle as stat_clear, set wins.
  - Status is not cleared by IDLE.

Test Plan:
- Reset, then enable=1 at cycle 0 -> state reads FLUSH for cycles 1–8 with dsm_reset=1; RUN from cycle 9; first sample_tick at cycle 9+64=73.
- Push 16'h1000 then 16'hF000 before the first tick -> dsm_vin=16'h1000 at tick 1 and 16'hF000 at tick 2. s_ready=0 while 2 entries are held and s_valid is high.
- No pushes after the 2 samples -> at tick 3 dsm_vin stays 16'hF000, underrun=1; stat_clear pulse -> underrun=0.
- In RUN, force pwm=01 for 32 consecutive cycles -> overload=1, state=RECOVER, dsm_reset=1 and dsm_vin=0 for 8 cycles, then RUN. With alternating 01/11, overload never sets.
- dith_en=1, default seed -> first RUN-cycle dsm_dith = sign-extended 16'hACE1>>>8 = 16'hFFAC. dith_en=0 -> dsm_dith=0.
- enable=0 mid-RECOVER, and separately assert reset mid-RUN -> IDLE next edge with the buffer empty. Under reset, all outputs return to reset values immediately.
